// File: rtl/ddr_deser_pkg.sv
// ddr_deser_pkg: shared FSM state type and pair-counter sizing for ddr_deser.
package ddr_deser_pkg;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width / 2) : 1;
  endfunction
endpackage

// File: rtl/ddr_pair_capture.sv
// ddr_pair_capture: samples the rise bit and enable on posedge and the fall bit on negedge.
module ddr_pair_capture (
  input  logic clk,
  input  logic rst_n,
  input  logic ddr_d,
  input  logic ddr_en,
  output logic r,
  output logic f,
  output logic en
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r  <= 1'b0;
      en <= 1'b0;
    end else begin
      r  <= ddr_d;
      en <= ddr_en;
    end
  end
  // f_k is settled half a cycle before posedge k+1, so the pair is consumed there
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) f <= 1'b0;
    else f <= ddr_d;
  end
endmodule

// File: rtl/ddr_deser.sv
// ddr_deser: DDR serial to WIDTH-bit valid/ready deserializer; DDR_DESER_LSB_FIRST_EN selects LSB-first packing.
module ddr_deser
  import ddr_deser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ddr_d,
  input  logic             ddr_en,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_abort,
  output logic             err_ovf
);
  localparam int CW = cnt_w(WIDTH);
  localparam int HALF = WIDTH / 2;
  logic r, f, en, done, abort;
  logic [WIDTH-1:0] sr, base, word;
  logic [CW-1:0] cnt, cnt_n;
  state_t state, state_n;
  ddr_pair_capture cap (.clk(clk), .rst_n(rst_n), .ddr_d(ddr_d), .ddr_en(ddr_en), .r(r), .f(f), .en(en));
  always_comb begin
    base = (state == ST_IDLE) ? '0 : sr;
`ifdef DDR_DESER_LSB_FIRST_EN
    word = (base >> 2) | (WIDTH'({f, r}) << (WIDTH - 2));
`else
    word = (base << 2) | WIDTH'({r, f});
`endif
    done = en && (cnt == CW'(HALF - 1));
    abort = !en && (state == ST_SHIFT);
    state_n = en ? (done ? ST_IDLE : ST_SHIFT) : ST_IDLE;
    cnt_n = (en && !done) ? cnt + 1'b1 : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt <= '0;
      sr <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (en) sr <= word;
    end
  end
  // a finished word is dropped only when the held word is not leaving on this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_valid <= 1'b0;
      err_abort <= 1'b0;
      err_ovf <= 1'b0;
    end else begin
      err_abort <= abort;
      if (done && out_valid && !out_ready) err_ovf <= 1'b1;
      else if (done) begin
        out_data <= word;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ddr_deser.sv
// tb_ddr_deser: directed checks of ddr_deser framing, handshake, abort, overflow and reset.
module tb_ddr_deser;
  logic clk = 0, rst_n = 0, ddr_d = 0, ddr_en = 0, out_ready = 1;
  logic [7:0] out_data;
  logic out_valid, err_abort, err_ovf;
  int total = 0, bad = 0, cyc = 0, aborts = 0;
  logic [7:0] wq[$];
  int cq[$];
  ddr_deser #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .ddr_d(ddr_d), .ddr_en(ddr_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_abort(err_abort), .err_ovf(err_ovf));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      wq.push_back(out_data);
      cq.push_back(cyc);
    end
    if (err_abort) aborts = aborts + 1;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] ex(input logic [7:0] s);
    logic [7:0] v;
`ifdef DDR_DESER_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) v[i] = s[7-i];
`else
    v = s;
`endif
    return v;
  endfunction
  task automatic send_pair(input logic rb, input logic fb, input logic e);
    @(negedge clk);
    #1 ddr_d = rb;
    ddr_en = e;
    @(posedge clk);
    #1 ddr_d = fb;
    ddr_en = 0;
  endtask
  task automatic send_word(input logic [7:0] s);
    for (int i = 3; i >= 0; i--) send_pair(s[2*i+1], s[2*i], 1'b1);
  endtask
  task automatic idle(input int n);
    repeat (n) send_pair(1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    #12;
    check("rst_data", out_data, 0);
    check("rst_valid", out_valid, 0);
    check("rst_ovf", err_ovf, 0);
    rst_n = 1;
    send_word(8'hA5);
    check("a5_latency", out_valid, 0);
    @(posedge clk);
    #1;
    check("a5_valid", out_valid, 1);
    check("a5_data", out_data, ex(8'hA5));
    check("a5_abort", err_abort, 0);
    check("a5_ovf", err_ovf, 0);
    idle(2);
    check("a5_drop", out_valid, 0);
    wq.delete();
    cq.delete();
    send_word(8'h3C);
    send_word(8'hC3);
    idle(2);
    check("b2b_count", wq.size(), 2);
    if (wq.size() == 2) begin
      check("b2b_w0", wq[0], ex(8'h3C));
      check("b2b_w1", wq[1], ex(8'hC3));
      check("b2b_gap", cq[1] - cq[0], 4);
    end
    wq.delete();
    aborts = 0;
    send_pair(1'b1, 1'b0, 1'b1);
    send_pair(1'b0, 1'b1, 1'b1);
    idle(3);
    check("abort_pulses", aborts, 1);
    check("abort_words", wq.size(), 0);
    send_word(8'h5A);
    idle(2);
    check("abort_next", wq.size(), 1);
    if (wq.size() == 1) check("abort_next_data", wq[0], ex(8'h5A));
    wq.delete();
    out_ready = 0;
    send_word(8'h11);
    send_word(8'h22);
    idle(2);
    check("ovf_valid", out_valid, 1);
    check("ovf_data", out_data, ex(8'h11));
    check("ovf_flag", err_ovf, 1);
    out_ready = 1;
    @(posedge clk);
    #1;
    check("ovf_drain", out_valid, 0);
    check("ovf_sticky", err_ovf, 1);
    check("ovf_accept", wq.size(), 1);
    if (wq.size() == 1) check("ovf_accept_data", wq[0], ex(8'h11));
    wq.delete();
    send_pair(1'b1, 1'b1, 1'b1);
    send_pair(1'b1, 1'b1, 1'b1);
    #2 rst_n = 0;
    #1;
    check("arst_data", out_data, 0);
    check("arst_ovf", err_ovf, 0);
    check("arst_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1;
    send_word(8'hFF);
    idle(2);
    check("post_rst_count", wq.size(), 1);
    if (wq.size() == 1) check("post_rst_data", wq[0], 8'hFF);
    check("post_rst_ovf", err_ovf, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
